// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two requesters share one bit-serial adder.
// A job is granted in IDLE (round-robin when both requesters are valid), its
// operands are added LSB first over WIDTH SHIFT cycles, and the result waits
// in DONE until the consumer accepts it.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   reqN_valid/ready      requester N handshake (ready is combinational)
//   reqN_a, reqN_b        requester N operands
//   res_valid/ready       result handshake
//   res_sum, res_cout     (a+b) mod 2^WIDTH and carry out
//   res_id                requester that owns the result
//   busy                  high whenever the FSM is not in IDLE
module serial_add_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             ptr_q;      // requester that wins when both are valid
    logic             job_id_q;   // owner of the job in flight
    logic [WIDTH-1:0] res_sum_q;
    logic             res_cout_q;
    logic             res_id_q;

    logic any_valid, grant_id, accept, bit_sum, bit_carry, last_shift;

    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_id   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        // Gated by reset so neither ready can pulse while reset is held.
        accept     = (state_q == StIdle) && any_valid && !reset;
        bit_sum    = a_q[0] ^ b_q[0] ^ carry_q;
        bit_carry  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_shift = (state_q == StShift) && (cnt_q == LastCnt);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (last_shift) state_d = StDone;
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        res_valid  = (state_q == StDone);
        busy       = (state_q != StIdle);
    end

    // Datapath: operand shifters, carry, counter, pointer and result latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            job_id_q   <= 1'b0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_id_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= grant_id ? req1_a : req0_a;
            b_q      <= grant_id ? req1_b : req0_b;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            job_id_q <= grant_id;
            ptr_q    <= ~grant_id;
        end else if (state_q == StShift) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            sum_q   <= {bit_sum, sum_q[WIDTH-1:1]};
            carry_q <= bit_carry;
            cnt_q   <= cnt_q + CW'(1);
            // Result outputs only change when a job completes, so they keep
            // the last finished result while the next job is shifting.
            if (last_shift) begin
                res_sum_q  <= {bit_sum, sum_q[WIDTH-1:1]};
                res_cout_q <= bit_carry;
                res_id_q   <= job_id_q;
            end
        end
    end

    assign res_sum  = res_sum_q;
    assign res_cout = res_cout_q;
    assign res_id   = res_id_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         res_valid, res_ready = 1'b1;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id, busy;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        int           acc;   // posedge number of the accept edge
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
    endtask

    // Monitor: latency on each res_valid rise, contents on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (res_valid && !prev_valid) begin
                if (q.size() > 0) check("latency", cyc, q[0].acc + W);
                else fail_now("unexpected_valid");
            end
            if (res_valid && res_ready) begin
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("res_sum", res_sum, e.sum);
                    check("res_cout", res_cout, e.cout);
                    check("res_id", res_id, e.id);
                end else begin
                    fail_now("unexpected_result");
                end
            end
        end
        prev_valid = res_valid;
    end

    // Offer one operand pair from a single requester; push expectation on grant.
    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec);
        bit   got;
        exp_t e;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        got = 0;
        for (int g = 0; g < 100 && !got; g++) begin
            @(negedge clk);
            if (id) check("req0_ready_low", req0_ready, 0);
            if (id ? req1_ready : req0_ready) begin
                got = 1;
                e.sum = es; e.cout = ec; e.id = id; e.acc = cyc + 1;
                q.push_back(e);
            end
        end
        if (!got) fail_now("grant_timeout");
        @(posedge clk); #1;
        // Scramble operands after accept; the running sum must not notice.
        req0_valid = 0; req1_valid = 0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    endtask

    task automatic drain();
        for (int g = 0; g < 100 && q.size() > 0; g++) @(negedge clk);
        if (q.size() > 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_sum"}, res_sum, 0);
        check({tag, "_res_cout"}, res_cout, 0);
        check({tag, "_res_id"}, res_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_order [4];
        int   k;
        bit   seen;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

        // Reset state, with a requester valid during reset
        req0_valid = 1;
        @(negedge clk);
        check_all_zero("reset");
        req0_valid = 0;
        @(posedge clk); #1 reset = 0;

        // Directed single-requester jobs
        issue(0, 4'b1100, 4'b1101, 4'b1001, 1'b1);
        drain();
        issue(1, 4'b1111, 4'b0000, 4'b1111, 1'b0);
        drain();
        issue(0, 4'b1111, 4'b0001, 4'b0000, 1'b1);
        drain();
        issue(1, 4'b0101, 4'b0011, 4'b1000, 1'b0);
        drain();

        // Both valid from reset: alternating grants, one-cycle ready pulses
        @(posedge clk); #1 reset = 1;
        req0_valid = 1; req0_a = 4'b0010; req0_b = 4'b0011;
        req1_valid = 1; req1_a = 4'b1000; req1_b = 4'b1001;
        @(posedge clk); #1 reset = 0;
        k = 0;
        for (int g = 0; g < 200 && k < 4; g++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                exp_t e;
                check("one_ready", req0_ready & req1_ready, 0);
                check("grant_order", req1_ready, exp_order[k]);
                e.id   = req1_ready;
                e.sum  = req1_ready ? 4'b0001 : 4'b0101;
                e.cout = req1_ready;
                e.acc  = cyc + 1;
                q.push_back(e);
                k++;
                if (k == 4) begin
                    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
                end else begin
                    @(negedge clk);
                    check("ready_pulse", {req0_ready, req1_ready}, 2'b00);
                end
            end
        end
        if (k < 4) fail_now("rr_timeout");
        drain();

        // Consumer stalls for 10 cycles in DONE
        res_ready = 0;
        issue(0, 4'b0110, 4'b0011, 4'b1001, 1'b0);
        req0_valid = 1; req1_valid = 1;
        seen = 0;
        for (int g = 0; g < 50 && !seen; g++) begin
            @(negedge clk);
            seen = res_valid;
        end
        if (!seen) fail_now("hold_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", res_valid, 1);
            check("hold_sum", res_sum, 4'b1001);
            check("hold_readys", {req0_ready, req1_ready}, 2'b00);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_hold", busy, 0);
        check("valid_after_hold", res_valid, 0);
        drain();

        // Reset two cycles into a job aborts it; next grant goes to req0
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 4'b0111; req0_b = 4'b0001;
        seen = 0;
        for (int g = 0; g < 100 && !seen; g++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        if (!seen) fail_now("abort_grant_timeout");
        @(posedge clk); #1 req0_valid = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1;
        req0_valid = 1; req0_a = 4'b0010; req0_b = 4'b0010;
        req1_valid = 1; req1_a = 4'b0001; req1_b = 4'b0001;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("post_reset_req0_ready", req0_ready, 1);
        check("post_reset_req1_ready", req1_ready, 0);
        if (req0_ready) begin
            exp_t e;
            e.sum = 4'b0100; e.cout = 0; e.id = 0; e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        drain();
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 pair accepted this cycle when valid&ready.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006, for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer takes result when valid&ready.
REQ-010 res_sum  output  WIDTH  (a+b) mod 2^WIDTH.
REQ-011 res_cout  output  1  carry out of bit WIDTH-1.
REQ-012 res_id  output  1  index of requester that owns the result.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; one addition in flight at a time.
REQ-015 IDLE grant: one valid -> grant it; both valid -> grant requester named by priority pointer; none -> stay IDLE.
REQ-016 reqN_ready is combinational and high only in IDLE for the granted requester; the other ready is 0.
REQ-017 On accept edge: load a/b shift registers, clear carry flop and bit counter, latch res_id, toggle priority pointer to the non-granted requester, go SHIFT.
REQ-018 Priority pointer changes only on accept; a lone requester is granted regardless of pointer.
REQ-019 SHIFT, each cycle: s = a[0]^b[0]^c; c <= majority(a[0],b[0],c); s shifted into sum register MSB; a, b shifted right; counter increments.
REQ-020 After WIDTH SHIFT cycles -> DONE; res_valid rises exactly WIDTH cycles after the accept edge.
REQ-021 DONE: res_valid=1; res_sum, res_cout, res_id stable until handshake completes.
REQ-022 res_valid&res_ready in DONE -> IDLE next edge; res_ready low -> remain in DONE indefinitely.
REQ-023 Earliest next accept is the cycle after result handshake (one IDLE cycle minimum between jobs).
REQ-024 Requester inputs ignored outside IDLE; operand changes after accept do not affect the running sum.
REQ-025 res_valid=0 in IDLE and SHIFT; res_sum/res_cout/res_id hold the last completed result outside DONE.
REQ-026 Overflow wraps: res_sum = (a+b) mod 2^WIDTH, res_cout = bit WIDTH of a+b.

Reset
REQ-027 reset high, any state: immediately go IDLE; res_valid, res_sum, res_cout, res_id, busy, both ready outputs = 0 while asserted.
REQ-028 Reset sets priority pointer to requester 0, clears shift registers, carry, counter.
REQ-029 Reset mid-SHIFT or in DONE aborts the job; no result delivered, job not re-executed.
REQ-030 First grant takes place no earlier than the first rising edge after reset deasserts.

Verification
REQ-031 WIDTH=4, req0 a=1100 b=1101, res_ready=1 -> res_valid 4 cycles after accept, res_sum=1001, res_cout=1, res_id=0.
REQ-032 req1 a=1111 b=0000 -> res_sum=1111, res_cout=0, res_id=1; req0_ready stays 0 throughout.
REQ-033 Both valid from reset, res_ready=1 -> grants in order req0, req1, req0, req1; every ready pulse is one cycle.
REQ-034 res_ready=0 for 10 cycles in DONE -> res_valid and res_sum held for all 10 cycles, both readys 0; IDLE one cycle after res_ready rises.
REQ-035 reset pulsed 2 cycles after accept of 0111+0001 -> res_valid never asserts; all outputs 0; next grant goes to req0 when both valid.
REQ-036 1111+0001 -> res_sum=0000, res_cout=1 (wrap-around).
